// File: rtl/bnn_pkg.sv
// Shared BNN datapath package: default widths, class count
// and the output-stage state encoding.
package bnn_pkg;

  localparam int BNN_ACC_WIDTH = 12;
  localparam int BNN_N_CLASSES = 10;
  localparam int BNN_IDX_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/argmax_cmp.sv
// Combinational argmax step: candidate vs. running best.
// Ports: first, cand_*, best_* in; out_score/out_idx out.
module argmax_cmp #(
  parameter int ACC_WIDTH = 12,
  parameter int IDX_WIDTH = 4
) (
  input  logic                 first,
  input  logic [ACC_WIDTH-1:0] cand_score,
  input  logic [IDX_WIDTH-1:0] cand_idx,
  input  logic [ACC_WIDTH-1:0] best_score,
  input  logic [IDX_WIDTH-1:0] best_idx,
  output logic [ACC_WIDTH-1:0] out_score,
  output logic [IDX_WIDTH-1:0] out_idx
);

  logic take;

  // strict greater keeps the lower index on ties
  always_comb begin
    take      = first | (cand_score > best_score);
    out_score = take ? cand_score : best_score;
    out_idx   = take ? cand_idx : best_idx;
  end

endmodule

// File: rtl/bnn_argmax_out.sv
// BNN output stage: streams final-layer popcounts, reports argmax.
// Ports: start, acc_* stream in, result_ack; class_*, frame_err, busy out.
module bnn_argmax_out
  import bnn_pkg::*;
#(
  parameter int ACC_WIDTH = BNN_ACC_WIDTH,
  parameter int N_CLASSES = BNN_N_CLASSES,
  parameter int IDX_WIDTH = BNN_IDX_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 acc_valid,
  input  logic [ACC_WIDTH-1:0] acc_data,
  input  logic                 acc_last,
  output logic                 acc_ready,
  input  logic                 result_ack,
  output logic                 class_valid,
  output logic [IDX_WIDTH-1:0] class_idx,
  output logic [ACC_WIDTH-1:0] class_score,
  output logic                 frame_err,
  output logic                 busy
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX =
    IDX_WIDTH'(N_CLASSES - 1);

  state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0] cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] best_score_q, best_score_d;
  logic [IDX_WIDTH-1:0] best_idx_q, best_idx_d;
  logic                 frame_err_q, frame_err_d;

  logic [ACC_WIDTH-1:0] cmp_score;
  logic [IDX_WIDTH-1:0] cmp_idx;
  logic                 xfer;

  argmax_cmp #(
    .ACC_WIDTH(ACC_WIDTH),
    .IDX_WIDTH(IDX_WIDTH)
  ) u_cmp (
    .first     (cnt_q == '0),
    .cand_score(acc_data),
    .cand_idx  (cnt_q),
    .best_score(best_score_q),
    .best_idx  (best_idx_q),
    .out_score (cmp_score),
    .out_idx   (cmp_idx)
  );

  // ready is a pure decode of the state register
  assign acc_ready = (state_q == ST_COLLECT);
  assign busy      = (state_q == ST_COLLECT);
  assign xfer      = acc_valid & acc_ready;

  assign class_valid = (state_q == ST_DONE);
  assign class_idx   = class_valid ? best_idx_q : '0;
  assign class_score = class_valid ? best_score_q : '0;
  assign frame_err   = frame_err_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    best_score_d = best_score_q;
    best_idx_d   = best_idx_q;
    frame_err_d  = frame_err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_COLLECT;
          cnt_d        = '0;
          best_score_d = '0;
          best_idx_d   = '0;
          frame_err_d  = 1'b0;
        end
      end
      ST_COLLECT: begin
        if (start) begin
          // abort: a word offered this cycle is dropped
          cnt_d        = '0;
          best_score_d = '0;
          best_idx_d   = '0;
          frame_err_d  = 1'b0;
        end else if (xfer) begin
          best_score_d = cmp_score;
          best_idx_d   = cmp_idx;
          if (cnt_q == LAST_IDX) begin
            state_d = ST_DONE;
            if (!acc_last) frame_err_d = 1'b1;
          end else if (acc_last) begin
            state_d     = ST_DONE;
            frame_err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + IDX_WIDTH'(1);
          end
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d      = ST_COLLECT;
          cnt_d        = '0;
          best_score_d = '0;
          best_idx_d   = '0;
          frame_err_d  = 1'b0;
        end else if (result_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      best_score_q <= '0;
      best_idx_q   <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      best_score_q <= best_score_d;
      best_idx_q   <= best_idx_d;
      frame_err_q  <= frame_err_d;
    end
  end

endmodule
